// File: rtl/vliw_pkg.sv
// Shared definitions for the VLIW issue controller and the control decoder.
package vliw_pkg;

  localparam int unsigned REG_ADDR_W_DEF = 4;

  localparam logic [4:0] STOREB = 5'b01100;
  localparam logic [4:0] LOADB  = 5'b01101;
  localparam logic [4:0] BRANCH = 5'b11010;
  localparam logic [4:0] JUMP   = 5'b11110;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2,
    TRAP     = 2'd3
  } issueState_t;

endpackage

// File: rtl/vliw_hazard_unit.sv
// Load-use comparator: flags a fetch bundle that reads the register a P1 loadb writes.
module vliw_hazard_unit
  import vliw_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  p1Valid,
  input  logic [4:0]            p1MemOpcode,
  input  logic [REG_ADDR_W-1:0] p1MemRd,
  input  logic                  fValid,
  input  logic [REG_ADDR_W-1:0] fAluRs1,
  input  logic [REG_ADDR_W-1:0] fAluRs2,
  input  logic [REG_ADDR_W-1:0] fMemRs,
  output logic                  loadUse
);

  logic srcMatch;

  always_comb begin
    srcMatch = (p1MemRd == fAluRs1) || (p1MemRd == fAluRs2) || (p1MemRd == fMemRs);
    // r0 is hardwired zero, so a load targeting it never creates a dependency
    loadUse  = p1Valid && fValid && (p1MemOpcode == LOADB) && (p1MemRd != '0) && srcMatch;
  end

endmodule

// File: rtl/vliw_issue_ctrl.sv
// Issue/sequencing controller for the 2-slot VLIW pipeline: P1 bundle register plus hazard FSM.
// Optional performance counters are enabled with `define VLIW_ISSUE_PERF_CNT_EN.
module vliw_issue_ctrl
  import vliw_pkg::*;
#(
  parameter int unsigned REG_ADDR_W    = REG_ADDR_W_DEF,
  parameter int unsigned FLUSH_BUBBLES = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  f_valid,
  output logic                  f_ready,
  input  logic [6:0]            f_aluOpcode,
  input  logic [4:0]            f_memOpcode,
  input  logic [REG_ADDR_W-1:0] f_aluRs1,
  input  logic [REG_ADDR_W-1:0] f_aluRs2,
  input  logic [REG_ADDR_W-1:0] f_aluRd,
  input  logic [REG_ADDR_W-1:0] f_memRs,
  input  logic [REG_ADDR_W-1:0] f_memRd,
  output logic                  p1_valid,
  output logic [6:0]            p1_aluOpcode,
  output logic [4:0]            p1_memOpcode,
  output logic [REG_ADDR_W-1:0] p1_aluRs1,
  output logic [REG_ADDR_W-1:0] p1_aluRs2,
  output logic [REG_ADDR_W-1:0] p1_aluRd,
  output logic [REG_ADDR_W-1:0] p1_memRs,
  output logic [REG_ADDR_W-1:0] p1_memRd,
  input  logic                  memRead,
  input  logic                  memWrite,
  input  logic                  isBranch,
  input  logic                  isJump,
  input  logic                  alu_undefinedInstruction,
  input  logic                  mem_undefinedInstruction,
  input  logic                  branchTaken,
  output logic                  dmem_req,
  input  logic                  dmem_ack,
  output logic                  pc_redirect,
  output logic                  stall,
  output logic                  trap
`ifdef VLIW_ISSUE_PERF_CNT_EN
  ,
  output logic [15:0]           perf_stall_cnt,
  output logic [15:0]           perf_flush_cnt
`endif
);

  issueState_t state, stateNext;
  logic [2:0]  flushCnt, flushCntNext;
  logic        loadP1, clearP1;
  logic        memOp, takenCtl, undefInsn, loadUse;

  vliw_hazard_unit #(.REG_ADDR_W(REG_ADDR_W)) hazardUnit (
    .p1Valid    (p1_valid),
    .p1MemOpcode(p1_memOpcode),
    .p1MemRd    (p1_memRd),
    .fValid     (f_valid),
    .fAluRs1    (f_aluRs1),
    .fAluRs2    (f_aluRs2),
    .fMemRs     (f_memRs),
    .loadUse    (loadUse)
  );

  assign memOp     = p1_valid && (memRead || memWrite);
  assign takenCtl  = p1_valid && (isJump || (isBranch && branchTaken));
  assign undefInsn = p1_valid && (alu_undefinedInstruction || mem_undefinedInstruction);
  assign dmem_req  = memOp && ((state == RUN) || (state == MEM_WAIT));
  assign trap      = (state == TRAP);

  always_comb begin
    stateNext    = state;
    flushCntNext = flushCnt;
    f_ready      = 1'b0;
    stall        = 1'b0;
    pc_redirect  = 1'b0;
    loadP1       = 1'b0;
    clearP1      = 1'b0;
    case (state)
      TRAP: clearP1 = 1'b1;
      FLUSH: begin
        f_ready      = 1'b1;
        clearP1      = 1'b1;
        flushCntNext = flushCnt - 3'd1;
        if (flushCnt <= 3'd1) begin
          stateNext    = RUN;
          flushCntNext = '0;
        end
      end
      // MEM_WAIT shares RUN's priority chain so the ack cycle also retires P1
      RUN, MEM_WAIT: begin
        if (undefInsn) begin
          stateNext = TRAP;
          clearP1   = 1'b1;
        end else if (memOp && !dmem_ack) begin
          stateNext = MEM_WAIT;
          stall     = 1'b1;
        end else if (takenCtl) begin
          pc_redirect = 1'b1;
          f_ready     = 1'b1;
          clearP1     = 1'b1;
          if (FLUSH_BUBBLES > 1) begin
            stateNext    = FLUSH;
            flushCntNext = 3'(FLUSH_BUBBLES - 1);
          end else begin
            stateNext = RUN;
          end
        end else if (loadUse) begin
          stateNext = RUN;
          stall     = 1'b1;
          clearP1   = 1'b1;
        end else begin
          stateNext = RUN;
          f_ready   = 1'b1;
          loadP1    = f_valid;
          clearP1   = !f_valid;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= RUN;
      flushCnt     <= '0;
      p1_valid     <= 1'b0;
      p1_aluOpcode <= '0;
      p1_memOpcode <= '0;
      p1_aluRs1    <= '0;
      p1_aluRs2    <= '0;
      p1_aluRd     <= '0;
      p1_memRs     <= '0;
      p1_memRd     <= '0;
    end else begin
      state    <= stateNext;
      flushCnt <= flushCntNext;
      if (loadP1) begin
        p1_valid     <= 1'b1;
        p1_aluOpcode <= f_aluOpcode;
        p1_memOpcode <= f_memOpcode;
        p1_aluRs1    <= f_aluRs1;
        p1_aluRs2    <= f_aluRs2;
        p1_aluRd     <= f_aluRd;
        p1_memRs     <= f_memRs;
        p1_memRd     <= f_memRd;
      end else if (clearP1) begin
        p1_valid     <= 1'b0;
        p1_aluOpcode <= '0;
        p1_memOpcode <= '0;
        p1_aluRs1    <= '0;
        p1_aluRs2    <= '0;
        p1_aluRd     <= '0;
        p1_memRs     <= '0;
        p1_memRd     <= '0;
      end
    end
  end

`ifdef VLIW_ISSUE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall && (perf_stall_cnt != '1))
        perf_stall_cnt <= perf_stall_cnt + 16'd1;
      if (pc_redirect && (perf_flush_cnt != '1))
        perf_flush_cnt <= perf_flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vliw_issue_ctrl.sv
// Directed bench for vliw_issue_ctrl: stimulus queues expected P1 bundles, a monitor retires and compares them.
module tb_vliw_issue_ctrl;
  import vliw_pkg::*;

  localparam int unsigned W = 4;
  localparam logic [4:0] MNOP = 5'b00001;

  typedef struct packed {
    logic [6:0]   alu;
    logic [4:0]   mem;
    logic [W-1:0] rs1, rs2, ard, mrs, mrd;
  } bundle_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, f_valid, f_ready;
  logic [6:0] f_aluOpcode, p1_aluOpcode;
  logic [4:0] f_memOpcode, p1_memOpcode;
  logic [W-1:0] f_aluRs1, f_aluRs2, f_aluRd, f_memRs, f_memRd;
  logic [W-1:0] p1_aluRs1, p1_aluRs2, p1_aluRd, p1_memRs, p1_memRd;
  logic p1_valid, memRead, memWrite, isBranch, isJump, aluUndef, memUndef;
  logic branchTaken, dmem_req, dmem_ack, pc_redirect, stall, trap;
`ifdef VLIW_ISSUE_PERF_CNT_EN
  logic [15:0] perf_stall_cnt, perf_flush_cnt;
`endif

  vliw_issue_ctrl #(.REG_ADDR_W(W), .FLUSH_BUBBLES(2)) dut (
    .clk(clk), .reset_n(reset_n), .f_valid(f_valid), .f_ready(f_ready),
    .f_aluOpcode(f_aluOpcode), .f_memOpcode(f_memOpcode),
    .f_aluRs1(f_aluRs1), .f_aluRs2(f_aluRs2), .f_aluRd(f_aluRd),
    .f_memRs(f_memRs), .f_memRd(f_memRd),
    .p1_valid(p1_valid), .p1_aluOpcode(p1_aluOpcode), .p1_memOpcode(p1_memOpcode),
    .p1_aluRs1(p1_aluRs1), .p1_aluRs2(p1_aluRs2), .p1_aluRd(p1_aluRd),
    .p1_memRs(p1_memRs), .p1_memRd(p1_memRd),
    .memRead(memRead), .memWrite(memWrite), .isBranch(isBranch), .isJump(isJump),
    .alu_undefinedInstruction(aluUndef), .mem_undefinedInstruction(memUndef),
    .branchTaken(branchTaken), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .pc_redirect(pc_redirect), .stall(stall), .trap(trap)
`ifdef VLIW_ISSUE_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  // Control decoder stand-in
  assign memRead  = (p1_memOpcode == LOADB);
  assign memWrite = (p1_memOpcode == STOREB);
  assign isBranch = (p1_memOpcode == BRANCH);
  assign isJump   = (p1_memOpcode == JUMP);
  assign memUndef = (p1_memOpcode == 5'b00000);
  assign aluUndef = (p1_aluOpcode == 7'h7F);

  // Data memory: acks after memLat cycles of an outstanding request (0 = same cycle)
  int unsigned memLat = 0;
  int unsigned reqAge = 0;
  assign dmem_ack = dmem_req && (reqAge >= memLat);
  always @(posedge clk) reqAge <= (dmem_req && !dmem_ack) ? reqAge + 1 : 0;

  bundle_t expQ[$];
  int errors = 0;
  int checks = 0;
  int unsigned stallCycles = 0, redirects = 0, reqCycles = 0, idleCycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a P1 bundle retires when valid, defined, and not waiting on memory
  always @(negedge clk) begin
    if (reset_n) begin
      stallCycles += 32'(stall);
      redirects   += 32'(pc_redirect);
      reqCycles   += 32'(dmem_req);
      idleCycles  += 32'(!p1_valid);
      if (p1_valid && !aluUndef && !memUndef && !(dmem_req && !dmem_ack)) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got bundle %0h expected none at %0t",
                   {p1_aluOpcode, p1_memOpcode, p1_aluRs1, p1_aluRs2, p1_aluRd, p1_memRs, p1_memRd}, $time);
        end else begin
          check("p1_bundle",
                {p1_aluOpcode, p1_memOpcode, p1_aluRs1, p1_aluRs2, p1_aluRd, p1_memRs, p1_memRd},
                32'(expQ.pop_front()));
        end
      end
    end
  end

  function automatic bundle_t mk(input logic [6:0] alu, input logic [4:0] mem,
                                 input logic [W-1:0] rs1, rs2, ard, mrs, mrd);
    mk = '{alu: alu, mem: mem, rs1: rs1, rs2: rs2, ard: ard, mrs: mrs, mrd: mrd};
  endfunction

  task automatic drive(input bundle_t b);
    f_aluOpcode = b.alu; f_memOpcode = b.mem;
    f_aluRs1 = b.rs1; f_aluRs2 = b.rs2; f_aluRd = b.ard;
    f_memRs = b.mrs; f_memRd = b.mrd;
    f_valid = 1'b1;
  endtask

  // Presents a bundle until transferred; returns cycles spent (called at posedge+1)
  task automatic send(input bundle_t b, output int unsigned cyc);
    logic acc;
    acc = 1'b0;
    cyc = 0;
    drive(b);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      acc = f_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (acc) break;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no f_ready expected transfer within 20 cycles");
    end
    f_valid = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    f_valid = 1'b0;
    branchTaken = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int unsigned cyc, s0, s1, r0, i0;
    bundle_t b;
    f_aluOpcode = '0; f_memOpcode = '0; f_aluRs1 = '0; f_aluRs2 = '0;
    f_aluRd = '0; f_memRs = '0; f_memRd = '0;
    doReset();

    @(negedge clk);
    check("rst_p1_valid", 32'(p1_valid), 32'd0);
    check("rst_trap", 32'(trap), 32'd0);
    check("rst_f_ready", 32'(f_ready), 32'd1);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_dmem_req", 32'(dmem_req), 32'd0);
    check("rst_pc_redirect", 32'(pc_redirect), 32'd0);
    check("rst_p1_fields", {25'd0, p1_aluOpcode}, 32'd0);
    @(posedge clk);
    #1;

    // 1: back-to-back bundles, zero-wait store in the middle
    s0 = stallCycles;
    b = mk(7'h11, MNOP, 1, 2, 3, 0, 0);    expQ.push_back(b); send(b, cyc); s1 = cyc;
    b = mk(7'h12, STOREB, 4, 5, 6, 7, 0);  expQ.push_back(b); send(b, cyc); s1 += cyc;
    b = mk(7'h13, MNOP, 8, 9, 10, 0, 0);   expQ.push_back(b); send(b, cyc); s1 += cyc;
    idle(2);
    check("b2b_cycles", s1, 32'd3);
    check("b2b_stalls", stallCycles - s0, 32'd0);

    // 2: load-use on rs1, then r0 destination, then memRs dependency
    b = mk(7'h01, LOADB, 0, 0, 0, 0, 5);   expQ.push_back(b); send(b, cyc);
    s0 = stallCycles;
    b = mk(7'h20, MNOP, 5, 0, 1, 0, 0);    expQ.push_back(b); send(b, cyc);
    check("lu_cycles", cyc, 32'd2);
    check("lu_stalls", stallCycles - s0, 32'd1);
    b = mk(7'h01, LOADB, 0, 0, 0, 0, 0);   expQ.push_back(b); send(b, cyc);
    s0 = stallCycles;
    b = mk(7'h21, MNOP, 0, 0, 2, 0, 0);    expQ.push_back(b); send(b, cyc);
    check("lu_r0_cycles", cyc, 32'd1);
    check("lu_r0_stalls", stallCycles - s0, 32'd0);
    b = mk(7'h01, LOADB, 0, 0, 0, 0, 3);   expQ.push_back(b); send(b, cyc);
    b = mk(7'h01, STOREB, 0, 0, 0, 3, 0);  expQ.push_back(b); send(b, cyc);
    check("lu_memrs_cycles", cyc, 32'd2);
    idle(2);

    doReset();

    // 3: store with a 3-cycle memory wait
    memLat = 3;
    b = mk(7'h01, STOREB, 0, 0, 0, 2, 0);  expQ.push_back(b); send(b, cyc);
    s0 = stallCycles; r0 = reqCycles;
    b = mk(7'h30, MNOP, 1, 1, 1, 0, 0);    expQ.push_back(b); send(b, cyc);
    memLat = 0;
    check("mw_cycles", cyc, 32'd4);
    check("mw_req_cycles", reqCycles - r0, 32'd4);
    check("mw_stalls", stallCycles - s0, 32'd3);
    idle(1);

    // 4: jump with two flush bubbles; A and B must be discarded
    b = mk(7'h01, JUMP, 0, 0, 0, 0, 0);    expQ.push_back(b); send(b, cyc);
    r0 = redirects;
    b = mk(7'h41, MNOP, 1, 0, 0, 0, 0);    send(b, cyc);
    i0 = idleCycles;
    b = mk(7'h42, MNOP, 2, 0, 0, 0, 0);    send(b, cyc);
    b = mk(7'h43, MNOP, 3, 0, 0, 0, 0);    expQ.push_back(b); send(b, cyc);
    check("jmp_bubbles", idleCycles - i0, 32'd2);
    idle(2);
    check("jmp_redirects", redirects - r0, 32'd1);
`ifdef VLIW_ISSUE_PERF_CNT_EN
    check("perf_stall_cnt", 32'(perf_stall_cnt), 32'd3);
    check("perf_flush_cnt", 32'(perf_flush_cnt), 32'd1);
`endif

    // 5: not-taken branch, then undefined mem opcode traps
    branchTaken = 1'b0;
    b = mk(7'h01, BRANCH, 0, 0, 0, 0, 0);  expQ.push_back(b); send(b, cyc);
    r0 = redirects; i0 = idleCycles;
    b = mk(7'h50, MNOP, 4, 4, 4, 0, 0);    expQ.push_back(b); send(b, cyc);
    check("br_nt_cycles", cyc, 32'd1);
    check("br_nt_bubbles", idleCycles - i0, 32'd0);
    check("br_nt_redirect", redirects - r0, 32'd0);
    b = mk(7'h01, 5'b00000, 0, 0, 0, 0, 0); send(b, cyc);
    drive(mk(7'h60, MNOP, 6, 6, 6, 0, 0));
    idle(3);
    @(negedge clk);
    check("trap_set", 32'(trap), 32'd1);
    check("trap_f_ready", 32'(f_ready), 32'd0);
    check("trap_p1_valid", 32'(p1_valid), 32'd0);
    @(posedge clk);
    #1;
    doReset();
    @(negedge clk);
    check("trap_cleared", 32'(trap), 32'd0);
    check("post_trap_f_ready", 32'(f_ready), 32'd1);
    check("sb_drained", 32'(expQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
